// File: rtl/dpll_pkg.sv
// dpll_pkg: types and default constants shared by the DPLL blocks
// (controller, lock detector, NCO and phase detector).
//   dpll_state_e : controller state encoding, also exported on the state port
//   DPLL_*       : default parameter values
package dpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_TRACK = 2'd3
    } dpll_state_e;

    localparam int DPLL_W          = 16;
    localparam int DPLL_AVG_LOG2   = 2;
    localparam int DPLL_MIN_W      = 4;
    localparam int DPLL_LOCK_TOL   = 2;
    localparam int DPLL_LOCK_CNT   = 8;
    localparam int DPLL_UNLOCK_TOL = 16;

endpackage

// File: rtl/dpll_lock_det.sv
// dpll_lock_det: lock qualification for the DPLL tracking loop.
// Compares a measurement against the current NCO word, counts consecutive
// good samples and drives the locked flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : synchronous clear of good counter and locked flag
//   i_chk       : evaluate i_meas_w against i_nco_w this cycle (tracking strobe)
//   i_meas_w    : measured fin high-time
//   i_nco_w     : current NCO word (register value, before any trim)
//   o_unlock    : combinational; sample is invalid or too far off (re-acquire)
//   o_locked    : registered lock indicator
module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int W          = DPLL_W,
    parameter int MIN_W      = DPLL_MIN_W,
    parameter int LOCK_TOL   = DPLL_LOCK_TOL,
    parameter int LOCK_CNT   = DPLL_LOCK_CNT,
    parameter int UNLOCK_TOL = DPLL_UNLOCK_TOL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_chk,
    input  logic [W-1:0] i_meas_w,
    input  logic [W-1:0] i_nco_w,
    output logic         o_unlock,
    output logic         o_locked
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] CNT_MAX     = LOCK_CNT[GW-1:0];
    localparam logic [W-1:0]  MIN_WORD    = MIN_W[W-1:0];
    localparam logic [W-1:0]  LOCK_WORD   = LOCK_TOL[W-1:0];
    localparam logic [W-1:0]  UNLOCK_WORD = UNLOCK_TOL[W-1:0];

    logic [W-1:0]  w_diff;
    logic          w_good;
    logic [GW-1:0] r_good_cnt;
    logic          r_locked;

    assign w_diff   = (i_meas_w >= i_nco_w) ? (i_meas_w - i_nco_w) : (i_nco_w - i_meas_w);
    assign o_unlock = (i_meas_w < MIN_WORD) || (w_diff > UNLOCK_WORD);
    assign w_good   = (w_diff <= LOCK_WORD);
    assign o_locked = r_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (i_clr) begin
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (i_chk) begin
            if (o_unlock) begin
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (w_good) begin
                if (r_good_cnt != CNT_MAX)
                    r_good_cnt <= r_good_cnt + 1'b1;
                // This strobe brings (or keeps) the run at LOCK_CNT.
                if (r_good_cnt >= CNT_MAX - 1'b1)
                    r_locked <= 1'b1;
            end else begin
                // Hysteresis band: break the run but keep the lock flag.
                r_good_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dpll_ctrl.sv
// dpll_ctrl: DPLL acquisition and tracking controller.
// Averages 2^AVG_LOG2 valid fin high-time measurements into an initial NCO
// word, then trims it with phase-detector pulses and reports lock.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : level enable, low returns to IDLE
//   meas_w     : measured fin high-time, valid with meas_vld
//   meas_vld   : one-cycle measurement strobe
//   pd_up/dn   : phase-detector trim requests
//   nco_w      : NCO frequency word
//   nco_load   : one-cycle pulse with a freshly averaged nco_w
//   locked     : lock indicator
//   state      : IDLE=0, ACQ=1, LOAD=2, TRACK=3
module dpll_ctrl
    import dpll_pkg::*;
#(
    parameter int W          = DPLL_W,
    parameter int AVG_LOG2   = DPLL_AVG_LOG2,
    parameter int MIN_W      = DPLL_MIN_W,
    parameter int LOCK_TOL   = DPLL_LOCK_TOL,
    parameter int LOCK_CNT   = DPLL_LOCK_CNT,
    parameter int UNLOCK_TOL = DPLL_UNLOCK_TOL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] meas_w,
    input  logic         meas_vld,
    input  logic         pd_up,
    input  logic         pd_dn,
    output logic [W-1:0] nco_w,
    output logic         nco_load,
    output logic         locked,
    output logic [1:0]   state
);

    localparam int AW    = W + AVG_LOG2;
    localparam int N_AVG = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] CNT_DONE = N_AVG[AVG_LOG2:0];
    localparam logic [W-1:0]      MIN_WORD = MIN_W[W-1:0];

    dpll_state_e         r_state;
    logic [AW-1:0]       r_acc;
    logic [AVG_LOG2:0]   r_cnt;
    logic [W-1:0]        r_nco_w;
    logic                r_nco_load;
    logic [W-1:0]        w_trim;
    logic                w_meas_ok;
    logic                w_unlock;
    logic                w_chk;
    logic                w_clr;

    assign w_meas_ok = (meas_w >= MIN_WORD);
    assign w_chk     = en && meas_vld && (r_state == ST_TRACK);
    // LOAD starts a fresh lock run; en low drops any lock.
    assign w_clr     = !en || (r_state == ST_LOAD);

    // Saturating trim of the current word; conflicting pulses cancel.
    always_comb begin
        w_trim = r_nco_w;
        if (pd_up && !pd_dn && (r_nco_w != '1))
            w_trim = r_nco_w + 1'b1;
        else if (pd_dn && !pd_up && (r_nco_w > MIN_WORD))
            w_trim = r_nco_w - 1'b1;
    end

    dpll_lock_det #(
        .W          (W),
        .MIN_W      (MIN_W),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_TOL (UNLOCK_TOL)
    ) u_lock_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_chk    (w_chk),
        .i_meas_w (meas_w),
        .i_nco_w  (r_nco_w),
        .o_unlock (w_unlock),
        .o_locked (locked)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_nco_w    <= '0;
            r_nco_load <= 1'b0;
        end else if (!en) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_nco_load <= 1'b0;
        end else begin
            r_nco_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_ACQ;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                ST_ACQ: begin
                    if (meas_vld && w_meas_ok) begin
                        r_acc <= r_acc + {{AVG_LOG2{1'b0}}, meas_w};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == CNT_DONE)
                            r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_nco_w    <= r_acc[AW-1:AVG_LOG2];
                    r_nco_load <= 1'b1;
                    r_state    <= ST_TRACK;
                end
                ST_TRACK: begin
                    if (meas_vld && w_unlock) begin
                        // Re-acquire; the word is kept as-is for the NCO.
                        r_state <= ST_ACQ;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_nco_w <= w_trim;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign nco_w    = r_nco_w;
    assign nco_load = r_nco_load;
    assign state    = r_state;

endmodule

// File: tb/tb_dpll_ctrl.sv
module tb_dpll_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] meas_w;
    logic        meas_vld;
    logic        pd_up;
    logic        pd_dn;
    logic [15:0] nco_w;
    logic        nco_load;
    logic        locked;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, written from the behavioural rules.
    int m_state;          // 0 idle, 1 acquiring, 2 load, 3 tracking
    int m_samples[$];     // accepted acquisition samples
    int m_nco;
    bit m_load;
    int m_good;
    bit m_locked;

    typedef struct {
        bit en; int meas; bit vld; bit up; bit dn;
        int e_nco; bit e_load; bit e_locked; int e_state;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    dpll_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .meas_w   (meas_w),
        .meas_vld (meas_vld),
        .pd_up    (pd_up),
        .pd_dn    (pd_dn),
        .nco_w    (nco_w),
        .nco_load (nco_load),
        .locked   (locked),
        .state    (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_samples.delete(); m_nco = 0; m_load = 0; m_good = 0; m_locked = 0;
    endtask

    task automatic model_step();
        int sum, d, nt;
        int mv;
        mv = int'(meas_w);
        if (!en) begin
            m_state = 0; m_samples.delete(); m_good = 0; m_locked = 0; m_load = 0;
        end else begin
            m_load = 0;
            case (m_state)
                0: begin m_state = 1; m_samples.delete(); end
                1: if (meas_vld && mv >= 4) begin
                       m_samples.push_back(mv);
                       if (m_samples.size() == 4) m_state = 2;
                   end
                2: begin
                       sum = 0;
                       foreach (m_samples[i]) sum += m_samples[i];
                       m_nco = sum / m_samples.size();
                       m_load = 1; m_good = 0; m_state = 3;
                   end
                default: begin
                       nt = m_nco;
                       if (pd_up && !pd_dn) nt = (m_nco + 1 > 65535) ? 65535 : m_nco + 1;
                       if (pd_dn && !pd_up) nt = (m_nco - 1 < 4) ? 4 : m_nco - 1;
                       if (meas_vld) begin
                           d = (mv > m_nco) ? mv - m_nco : m_nco - mv;
                           if (mv < 4 || d > 16) begin
                               m_locked = 0; m_good = 0; m_state = 1;
                               m_samples.delete(); nt = m_nco;
                           end else if (d > 2) begin
                               m_good = 0;
                           end else begin
                               if (m_good < 8) m_good++;
                               if (m_good == 8) m_locked = 1;
                           end
                       end
                       m_nco = nt;
                   end
            endcase
        end
    endtask

    // One clock: model advances with the DUT, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("nco_w",    int'(nco_w),    m_nco);
        chk("nco_load", int'(nco_load), int'(m_load));
        chk("locked",   int'(locked),   int'(m_locked));
        chk("state",    int'(state),    m_state);
    endtask

    task automatic drive(input bit e, input int m, input bit v, input bit u, input bit d);
        en = e; meas_w = m[15:0]; meas_vld = v; pd_up = u; pd_dn = d;
    endtask

    task automatic strobe(input int m);
        drive(1, m, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
    endtask

    task automatic add(input bit e, input int m, input bit v, input bit u, input bit d,
                       input int n, input bit l, input bit k, input int s);
        vec_t x;
        x.en = e; x.meas = m; x.vld = v; x.up = u; x.dn = d;
        x.e_nco = n; x.e_load = l; x.e_locked = k; x.e_state = s;
        vt.push_back(x);
    endtask

    task automatic acquire4(input int v);
        for (int i = 0; i < 4; i++) strobe(v);
        drive(1, 0, 0, 0, 0); tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_nco_w", int'(nco_w), 0);
        chk("rst_nco_load", int'(nco_load), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_state", int'(state), 0);
        @(negedge clk); rst_n = 1'b1;
        #1;

        // Acquisition 100,102,98,104 -> 101, then trims, then lock/hysteresis/unlock.
        add(1,   0,0,0,0,   0,0,0,1);
        add(1, 100,1,0,0,   0,0,0,1);
        add(1, 102,1,0,0,   0,0,0,1);
        add(1,  98,1,0,0,   0,0,0,1);
        add(1, 104,1,0,0,   0,0,0,2);
        add(1,   0,0,0,0, 101,1,0,3);
        add(1,   0,0,0,0, 101,0,0,3);
        add(1,   0,0,1,0, 102,0,0,3);
        add(1,   0,0,1,0, 103,0,0,3);
        add(1,   0,0,1,1, 103,0,0,3);
        add(1,   0,0,1,0, 104,0,0,3);
        add(1,   0,0,0,0, 104,0,0,3);
        for (int i = 1; i <= 8; i++) add(1, 105,1,0,0, 104,0,(i == 8),3);
        add(1, 113,1,0,0, 104,0,1,3);
        add(1, 124,1,0,0, 104,0,0,1);
        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].meas, vt[i].vld, vt[i].up, vt[i].dn);
            tick();
            chk($sformatf("vec%0d_nco", i),    int'(nco_w),    vt[i].e_nco);
            chk($sformatf("vec%0d_load", i),   int'(nco_load), int'(vt[i].e_load));
            chk($sformatf("vec%0d_locked", i), int'(locked),   int'(vt[i].e_locked));
            chk($sformatf("vec%0d_state", i),  int'(state),    vt[i].e_state);
        end

        // Invalid samples in acquisition are discarded.
        strobe(100); strobe(0); strobe(3); strobe(100); strobe(100);
        chk("inv_state_acq", int'(state), 1);
        strobe(100);
        chk("inv_nco", int'(nco_w), 100);
        chk("inv_state", int'(state), 3);

        // Upper saturation.
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        acquire4(65535);
        chk("sat_hi_load", int'(nco_w), 65535);
        drive(1, 0, 0, 1, 0); tick(); tick();
        chk("sat_hi_hold", int'(nco_w), 65535);
        drive(1, 0, 0, 0, 1); tick();
        chk("sat_hi_dec", int'(nco_w), 65534);

        // Lower saturation.
        drive(0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        acquire4(4);
        drive(1, 0, 0, 0, 1); tick(); tick();
        chk("sat_lo_hold", int'(nco_w), 4);

        // Enable abort: stale partial average must not survive.
        drive(0, 0, 0, 0, 0); tick();
        chk("abort_idle", int'(state), 0);
        drive(1, 0, 0, 0, 0); tick();
        strobe(200); strobe(200);
        drive(0, 0, 0, 0, 0); tick();
        chk("abort_idle2", int'(state), 0);
        drive(1, 0, 0, 0, 0); tick();
        strobe(50); strobe(50); strobe(50);
        chk("abort_still_acq", int'(state), 1);
        strobe(50);
        chk("abort_nco", int'(nco_w), 50);

        // Lock, then asynchronous reset mid-track.
        for (int i = 0; i < 8; i++) strobe(51);
        chk("pre_rst_locked", int'(locked), 1);
        drive(1, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_nco", int'(nco_w), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_load", int'(nco_load), 0);
        @(negedge clk); rst_n = 1'b1;
        drive(1, 0, 0, 0, 0); tick();
        chk("arst_restart", int'(state), 1);

        // Randomized stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            int base, mv;
            base = (m_state == 3) ? m_nco : 100 + (c / 500) * 1000;
            mv = base + int'($urandom_range(0, 44)) - 22;
            if ($urandom_range(0, 19) == 0) mv = int'($urandom_range(0, 3));
            if (mv < 0) mv = 0;
            if (mv > 65535) mv = 65535;
            drive(($urandom_range(0, 199) != 0), mv, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
